// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Purpose  : Shared types and constants for the intersection phase controller:
//            phase state enum, one-hot lamp encodings {red, yellow, green},
//            default tick counts, and small helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_ALL_RED_2 = 3'd0,
        ST_NS_GREEN  = 3'd1,
        ST_NS_YELLOW = 3'd2,
        ST_ALL_RED_1 = 3'd3,
        ST_EW_GREEN  = 3'd4,
        ST_EW_YELLOW = 3'd5
    } state_t;

    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;

    localparam int c_GREEN_TICKS_DEF  = 4;
    localparam int c_YELLOW_TICKS_DEF = 1;
    localparam int c_RED_TICKS_DEF    = 1;
    localparam int c_WALK_TICKS_DEF   = 2;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic [2:0] ns_lamp(input state_t s);
        case (s)
            ST_NS_GREEN:  return c_GRN;
            ST_NS_YELLOW: return c_YEL;
            default:      return c_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_t s);
        case (s)
            ST_EW_GREEN:  return c_GRN;
            ST_EW_YELLOW: return c_YEL;
            default:      return c_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_ctrl_tick.sv
`default_nettype none
// ============================================================================
// Module   : phase_tick_cnt
// Purpose  : Saturating tick counter for one light phase. Counts enable
//            pulses, holds at limit-1, and flags terminal count when an
//            enable pulse arrives while already at limit-1.
// Ports    : tclk  - clock (posedge)
//            rst   - synchronous active-high reset
//            clr   - synchronous clear (phase change)
//            en    - count enable (timer expiration pulse)
//            limit - phase length in ticks (>=1)
//            tc    - terminal count: this pulse ends the phase
// Revision : 1.0 - initial release
// ============================================================================
module phase_tick_cnt #(
    parameter int W = 3
) (
    input  logic         tclk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] r_cnt;
    logic         w_at_lim;

    // ">=" rather than "==" so a runtime limit change never lets it run past.
    assign w_at_lim = (r_cnt >= (limit - W'(1)));
    assign tc       = en && w_at_lim;

    always_ff @(posedge tclk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en && !w_at_lim) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl
// Purpose  : Two-way intersection phase controller. Restarts the countdown
//            timer (ct), counts its expirations (t) to time each phase and
//            drives one-hot {red, yellow, green} lamps for both roads.
// Ports    : tclk     - clock (posedge)
//            rst      - synchronous active-high reset
//            t        - timer expiration pulse
//            ew_car   - east-west vehicle sensor (level)
//            ped_req  - pedestrian button (level or pulse)
//            ct       - timer restart, registered rst|t
//            ns_light - north-south lamps, one-hot
//            ew_light - east-west lamps, one-hot
//            walk     - pedestrian walk lamp
// Config   : PED_XING_EN - when defined, all-red phases can host a walk
//            interval of WALK_TICKS; otherwise ped_req is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = c_GREEN_TICKS_DEF,
    parameter int YELLOW_TICKS = c_YELLOW_TICKS_DEF,
    parameter int RED_TICKS    = c_RED_TICKS_DEF,
    parameter int WALK_TICKS   = c_WALK_TICKS_DEF
) (
    input  logic       tclk,
    input  logic       rst,
    input  logic       t,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic       ct,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk
);

    localparam int c_CNT_W = $clog2(max4(GREEN_TICKS, YELLOW_TICKS, RED_TICKS, WALK_TICKS)) + 1;

    localparam logic [c_CNT_W-1:0] c_LIM_GRN  = c_CNT_W'(GREEN_TICKS);
    localparam logic [c_CNT_W-1:0] c_LIM_YEL  = c_CNT_W'(YELLOW_TICKS);
    localparam logic [c_CNT_W-1:0] c_LIM_RED  = c_CNT_W'(RED_TICKS);
    localparam logic [c_CNT_W-1:0] c_LIM_WALK = c_CNT_W'(WALK_TICKS);

    state_t             r_state;
    state_t             w_next;
    logic               r_ew_wait;
    logic               r_ct;
    logic               r_walk;
    logic [2:0]         r_ns;
    logic [2:0]         r_ew;
    logic [c_CNT_W-1:0] w_limit;
    logic               w_tc;
    logic               w_chg;
    logic               w_enter_red;

`ifdef PED_XING_EN
    logic               r_ped_wait;
`else
    logic               w_unused_ped;
    assign w_unused_ped = ped_req;
`endif

    // Phase length for the current state; an all-red hosting a walk is longer.
    always_comb begin
        w_limit = c_LIM_RED;
        case (r_state)
            ST_NS_GREEN, ST_EW_GREEN:   w_limit = c_LIM_GRN;
            ST_NS_YELLOW, ST_EW_YELLOW: w_limit = c_LIM_YEL;
            default:                    w_limit = r_walk ? c_LIM_WALK : c_LIM_RED;
        endcase
    end

    phase_tick_cnt #(
        .W (c_CNT_W)
    ) u_tick (
        .tclk  (tclk),
        .rst   (rst),
        .clr   (w_chg),
        .en    (t),
        .limit (w_limit),
        .tc    (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ALL_RED_2: if (w_tc) w_next = ST_NS_GREEN;
            // NS green holds past its minimum until east-west demand exists.
            ST_NS_GREEN:  if (w_tc && (r_ew_wait || ew_car)) w_next = ST_NS_YELLOW;
            ST_NS_YELLOW: if (w_tc) w_next = ST_ALL_RED_1;
            ST_ALL_RED_1: if (w_tc) w_next = ST_EW_GREEN;
            ST_EW_GREEN:  if (w_tc) w_next = ST_EW_YELLOW;
            ST_EW_YELLOW: if (w_tc) w_next = ST_ALL_RED_2;
            default:      w_next = ST_ALL_RED_2;
        endcase
    end

    assign w_chg       = (w_next != r_state);
    assign w_enter_red = w_chg && ((w_next == ST_ALL_RED_1) || (w_next == ST_ALL_RED_2));

    always_ff @(posedge tclk) begin
        if (rst) begin
            r_state   <= ST_ALL_RED_2;
            r_ew_wait <= 1'b0;
            r_ct      <= 1'b1;
            r_walk    <= 1'b0;
            r_ns      <= c_RED;
            r_ew      <= c_RED;
`ifdef PED_XING_EN
            r_ped_wait <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_ct    <= t;
            // Lamps decoded from the next state so they move with the state.
            r_ns    <= ns_lamp(w_next);
            r_ew    <= ew_lamp(w_next);

            // Demand is consumed when NS green yields, so a car seen on that
            // same cycle does not trigger a second, spurious early exit.
            if (w_chg && ((r_state == ST_NS_GREEN) || (w_next == ST_EW_GREEN))) begin
                r_ew_wait <= 1'b0;
            end else if (ew_car) begin
                r_ew_wait <= 1'b1;
            end

`ifdef PED_XING_EN
            if (w_enter_red) begin
                r_walk     <= r_ped_wait || ped_req;
                r_ped_wait <= 1'b0;
            end else begin
                if (w_chg) begin
                    r_walk <= 1'b0;
                end
                if (ped_req) begin
                    r_ped_wait <= 1'b1;
                end
            end
`else
            r_walk <= 1'b0;
`endif
        end
    end

`ifndef PED_XING_EN
    logic w_unused_enter;
    assign w_unused_enter = w_enter_red;
`endif

    assign ct       = r_ct;
    assign ns_light = r_ns;
    assign ew_light = r_ew;
    assign walk     = r_walk;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_ctrl
// Purpose  : Self-checking bench for traffic_phase_ctrl. A phase-index
//            reference model (phase list, tick count, demand flags) predicts
//            ct, lamps and walk every cycle; directed scenarios add explicit
//            constant expectations, then randomized traffic runs.
// Config   : honours PED_XING_EN the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    localparam int G = 4;
    localparam int Y = 1;
    localparam int R = 1;
    localparam int W = 2;
`ifdef PED_XING_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    logic       tclk = 1'b0;
    logic       rst = 1'b1;
    logic       t = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic       ct;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;

    int vectors = 0;
    int miscompares = 0;

    traffic_phase_ctrl #(
        .GREEN_TICKS  (G),
        .YELLOW_TICKS (Y),
        .RED_TICKS    (R),
        .WALK_TICKS   (W)
    ) dut (
        .tclk     (tclk),
        .rst      (rst),
        .t        (t),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .ct       (ct),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk)
    );

    always #5 tclk = ~tclk;

    // Reference model: phase index into the fixed cycle AR2,NSG,NSY,AR1,EWG,EWY.
    logic [2:0] ns_tab [6] = '{RED, GRN, YEL, RED, RED, RED};
    logic [2:0] ew_tab [6] = '{RED, RED, RED, RED, GRN, YEL};
    int m_phase = 0;
    int m_ticks = 0;
    bit m_eww   = 1'b0;
    bit m_pedw  = 1'b0;
    bit m_walk  = 1'b0;
    bit m_ct    = 1'b1;

    task automatic model_step(input bit r, input bit tt, input bit e, input bit p);
        int dur;
        int nph;
        bit adv;
        if (r) begin
            m_phase = 0; m_ticks = 0; m_eww = 0; m_pedw = 0; m_walk = 0; m_ct = 1;
            return;
        end
        m_ct = tt;
        if (m_phase == 1 || m_phase == 4)      dur = G;
        else if (m_phase == 2 || m_phase == 5) dur = Y;
        else                                   dur = m_walk ? W : R;
        adv = 1'b0;
        if (tt) begin
            if (m_ticks + 1 >= dur) adv = (m_phase != 1) || m_eww || e;
            else                    m_ticks = m_ticks + 1;
        end
        if (adv) begin
            nph = (m_phase + 1) % 6;
            if (m_phase == 1 || nph == 4) m_eww = 1'b0;
            else                          m_eww = m_eww | e;
            if (nph == 0 || nph == 3) begin
                m_walk = PED && (m_pedw || p);
                m_pedw = 1'b0;
            end else begin
                m_walk = 1'b0;
                if (PED && p) m_pedw = 1'b1;
            end
            m_phase = nph;
            m_ticks = 0;
        end else begin
            m_eww = m_eww | e;
            if (PED && p) m_pedw = 1'b1;
        end
    endtask

    function automatic logic [7:0] exp_vec();
        return {m_ct, ns_tab[m_phase], ew_tab[m_phase], m_walk};
    endfunction

    // One clock: drive, let the edge sample, advance the model, settle.
    task automatic apply(input bit r, input bit tt, input bit e, input bit p);
        rst = r; t = tt; ew_car = e; ped_req = p;
        @(posedge tclk);
        model_step(r, tt, e, p);
        #1;
    endtask

    task automatic test_reset();
        for (int j = 0; j < 3; j++) begin
            apply(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            vectors++;
            if ({ct, ns_light, ew_light, walk} !== {1'b1, RED, RED, 1'b0}) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b expected %b", j,
                         {ct, ns_light, ew_light, walk}, {1'b1, RED, RED, 1'b0});
            end
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({ct, ns_light} !== {1'b0, RED}) begin
            miscompares++;
            $display("FAIL reset_release: got ct=%b ns=%b expected ct=0 ns=100", ct, ns_light);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({ct, ns_light, ew_light} !== {1'b1, GRN, RED}) begin
            miscompares++;
            $display("FAIL first_t: got ct=%b ns=%b ew=%b expected ct=1 ns=001 ew=100",
                     ct, ns_light, ew_light);
        end
    endtask

    task automatic test_ns_to_ew();
        // Already in NS green; 4 ticks with a car, then yellow, all-red, EW green.
        int nt;
        nt = PED ? 0 : 0;
        for (int j = 0; j < 12; j++) begin
            apply(1'b0, (j % 2 == 0), 1'b1, 1'b0);
            if (j % 2 == 0) nt++;
            vectors++;
            if ({ct, ns_light, ew_light, walk} !== exp_vec()) begin
                miscompares++;
                $display("FAIL ns_to_ew cyc %0d: got %b expected %b", j,
                         {ct, ns_light, ew_light, walk}, exp_vec());
            end
        end
        vectors++;
        if (ew_light !== GRN || nt != 6) begin
            miscompares++;
            $display("FAIL ns_to_ew_end: got ew=%b expected 001", ew_light);
        end
    endtask

    task automatic test_green_hold();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            apply(1'b0, (j % 2 == 0), 1'b0, 1'b0);
            vectors++;
            if (ns_light !== GRN || {ct, ns_light, ew_light, walk} !== exp_vec()) begin
                miscompares++;
                $display("FAIL green_hold cyc %0d: got %b expected ns=001 / %b", j,
                         {ct, ns_light, ew_light, walk}, exp_vec());
            end
        end
        apply(1'b0, 1'b0, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (ns_light !== YEL || {ct, ns_light, ew_light, walk} !== exp_vec()) begin
            miscompares++;
            $display("FAIL green_release: got ns=%b expected 010", ns_light);
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        // AR2 ->NSG (1), 4 ->NSY, 1 ->AR1, 1 ->EWG, 4 ->EWY: 11 ticks.
        for (int j = 0; j < 22; j++) apply(1'b0, (j % 2 == 0), 1'b1, 1'b0);
        vectors++;
        if (ew_light !== YEL) begin
            miscompares++;
            $display("FAIL reach_ew_yellow: got ew=%b expected 010", ew_light);
        end
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({ct, ns_light, ew_light, walk} !== {1'b1, RED, RED, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got %b expected %b",
                     {ct, ns_light, ew_light, walk}, {1'b1, RED, RED, 1'b0});
        end
        // Stale demand must be gone: NS green should now hold without a car.
        for (int j = 0; j < 12; j++) begin
            apply(1'b0, (j % 2 == 0), 1'b0, 1'b0);
            vectors++;
            if ({ct, ns_light, ew_light, walk} !== exp_vec()) begin
                miscompares++;
                $display("FAIL ew_wait_cleared cyc %0d: got %b expected %b", j,
                         {ct, ns_light, ew_light, walk}, exp_vec());
            end
        end
    endtask

    task automatic test_ped();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 10; j++) apply(1'b0, (j % 2 == 0), 1'b1, 1'b0);
        vectors++;
        if ({ns_light, ew_light, walk} !== {RED, RED, PED}) begin
            miscompares++;
            $display("FAIL ped_walk_on: got %b expected %b",
                     {ns_light, ew_light, walk}, {RED, RED, PED});
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (ew_light !== (PED ? RED : GRN)) begin
            miscompares++;
            $display("FAIL ped_walk_len: got ew=%b expected %b", ew_light, PED ? RED : GRN);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({walk, ew_light} !== {1'b0, PED ? GRN : GRN} && PED) begin
            miscompares++;
            $display("FAIL ped_walk_off: got walk=%b ew=%b expected walk=0 ew=001", walk, ew_light);
        end
        vectors++;
        if ({ct, ns_light, ew_light, walk} !== exp_vec()) begin
            miscompares++;
            $display("FAIL ped_model: got %b expected %b", {ct, ns_light, ew_light, walk}, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        apply(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) apply(1'b0, (j % 2 == 0), 1'b1, 1'b0);
        vectors++;
        if (ns_light !== YEL) begin
            miscompares++;
            $display("FAIL b2b_setup: got ns=%b expected 010", ns_light);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({ns_light, ew_light} !== {RED, RED} || {ct, ns_light, ew_light, walk} !== exp_vec()) begin
            miscompares++;
            $display("FAIL b2b_first: got %b expected %b", {ct, ns_light, ew_light, walk}, exp_vec());
        end
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({ct, ns_light, ew_light, walk} !== exp_vec()) begin
            miscompares++;
            $display("FAIL b2b_second: got %b expected %b", {ct, ns_light, ew_light, walk}, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 600; j++) begin
            apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            vectors++;
            if ({ct, ns_light, ew_light, walk} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b expected %b", j,
                         {ct, ns_light, ew_light, walk}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_ns_to_ew();
        test_green_hold();
        test_reset_mid();
        test_ped();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
